parity_gen_chk: RTL and testbench

- Parametrised parity unit for the UART datapath: generates the parity bit for a TX frame from parallel data, and checks received parity bit-serially for the RX deserializer.
- Supports five parity modes and any data width from 5 to 9 bits.
- Configuration is latched per operation, so the UART FSMs can change settings between frames safely.
- Sits between the TX/RX FSMs and the serializer/deserializer.

---
 rtl/parity_gen_chk_pkg.sv | 46 ++++
 rtl/parity_gen_chk_if.sv | 28 ++
 rtl/parity_serial_chk.sv | 79 +++++++
 rtl/parity_gen_chk.sv | 54 +++++
 tb/tb_parity_gen_chk.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/parity_gen_chk_pkg.sv
// Shared constants, encodings and parity helpers for the UART parity unit.
package parity_gen_chk_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int PAR_MODE_W = 3;

    typedef enum logic [PAR_MODE_W-1:0] {
        PAR_NONE  = 3'b000,
        PAR_EVEN  = 3'b001,
        PAR_ODD   = 3'b010,
        PAR_MARK  = 3'b011,
        PAR_SPACE = 3'b100
    } par_mode_e;

    typedef enum logic [1:0] {
        CHK_IDLE,
        CHK_ACCUM,
        CHK_WAIT_PAR,
        CHK_DONE
    } chk_state_e;

    // Encodings 101..111 fall through to the default and behave as none.
    function automatic logic has_parity(input logic [PAR_MODE_W-1:0] mode);
        logic en;
        en = 1'b0;
        case (mode)
            PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE: en = 1'b1;
            default:                                en = 1'b0;
        endcase
        return en;
    endfunction

    function automatic logic expected_parity(input logic [PAR_MODE_W-1:0] mode,
                                             input logic xor_acc);
        logic p;
        p = 1'b0;
        case (mode)
            PAR_EVEN: p = xor_acc;
            PAR_ODD:  p = ~xor_acc;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/parity_gen_chk_if.sv
// Signal bundle between the UART TX/RX FSMs and the parity unit.
interface parity_gen_chk_if #(
    parameter int WIDTH  = parity_gen_chk_pkg::DEF_WIDTH,
    parameter int MODE_W = parity_gen_chk_pkg::PAR_MODE_W
);
    logic [WIDTH-1:0]  P_DATA;
    logic              Data_Valid;
    logic [MODE_W-1:0] par_mode;
    logic              par_bit;
    logic              par_en;
    logic              par_valid;
    logic              ser_start;
    logic              ser_en;
    logic              ser_bit;
    logic              chk_busy;
    logic              chk_done;
    logic              par_err;

    modport master (
        output P_DATA, Data_Valid, par_mode, ser_start, ser_en, ser_bit,
        input  par_bit, par_en, par_valid, chk_busy, chk_done, par_err
    );

    modport slave (
        input  P_DATA, Data_Valid, par_mode, ser_start, ser_en, ser_bit,
        output par_bit, par_en, par_valid, chk_busy, chk_done, par_err
    );
endinterface

// File: rtl/parity_serial_chk.sv
// Bit-serial RX parity checker: accumulates WIDTH data bits, then compares
// the received parity bit against the mode latched at ser_start.
module parity_serial_chk
    import parity_gen_chk_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MODE_W = PAR_MODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_start,
    input  logic              ser_en,
    input  logic              ser_bit,
    input  logic [MODE_W-1:0] mode,
    output logic              chk_busy,
    output logic              chk_done,
    output logic              par_err
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    chk_state_e        state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic              acc;
    logic              err;
    logic [MODE_W-1:0] mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CHK_IDLE;
        else        state <= state_n;
    end

    // ser_start overrides everything, including a same-cycle ser_en.
    always_comb begin
        state_n  = state;
        chk_busy = (state != CHK_IDLE);
        chk_done = (state == CHK_DONE);
        if (ser_start) begin
            state_n = CHK_ACCUM;
        end else begin
            case (state)
                CHK_IDLE: state_n = CHK_IDLE;
                CHK_ACCUM: begin
                    if (ser_en && cnt == LAST)
                        state_n = has_parity(PAR_MODE_W'(mode_q)) ? CHK_WAIT_PAR : CHK_DONE;
                end
                CHK_WAIT_PAR: if (ser_en) state_n = CHK_DONE;
                CHK_DONE:     state_n = CHK_IDLE;
                default:      state_n = CHK_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= 1'b0;
            err    <= 1'b0;
            mode_q <= '0;
        end else if (ser_start) begin
            cnt    <= '0;
            acc    <= 1'b0;
            err    <= 1'b0;
            mode_q <= mode;
        end else if (ser_en) begin
            case (state)
                CHK_ACCUM: begin
                    acc <= acc ^ ser_bit;
                    cnt <= cnt + CNT_W'(1);
                end
                CHK_WAIT_PAR: err <= (ser_bit != expected_parity(PAR_MODE_W'(mode_q), acc));
                default: ;
            endcase
        end
    end

    assign par_err = err;

endmodule

// File: rtl/parity_gen_chk.sv
// UART parity unit: one-cycle TX parity generator plus the serial RX checker.
module parity_gen_chk
    import parity_gen_chk_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MODE_W = PAR_MODE_W
) (
    input  logic             CLK,
    input  logic             RST,
    parity_gen_chk_if.slave  bus
);
    logic [WIDTH-1:0]  gen_data;
    logic [MODE_W-1:0] gen_mode;
    logic              par_bit_q;
    logic              par_en_q;
    logic              par_valid_q;

    assign gen_data = bus.P_DATA;
    assign gen_mode = bus.par_mode;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit_q   <= 1'b0;
            par_en_q    <= 1'b0;
            par_valid_q <= 1'b0;
        end else begin
            par_valid_q <= bus.Data_Valid;
            if (bus.Data_Valid) begin
                par_bit_q <= expected_parity(PAR_MODE_W'(gen_mode), ^gen_data);
                par_en_q  <= has_parity(PAR_MODE_W'(gen_mode));
            end
        end
    end

    assign bus.par_bit   = par_bit_q;
    assign bus.par_en    = par_en_q;
    assign bus.par_valid = par_valid_q;

    parity_serial_chk #(
        .WIDTH  (WIDTH),
        .MODE_W (MODE_W)
    ) u_chk (
        .clk       (CLK),
        .rst_n     (RST),
        .ser_start (bus.ser_start),
        .ser_en    (bus.ser_en),
        .ser_bit   (bus.ser_bit),
        .mode      (bus.par_mode),
        .chk_busy  (bus.chk_busy),
        .chk_done  (bus.chk_done),
        .par_err   (bus.par_err)
    );

endmodule

// File: tb/tb_parity_gen_chk.sv
// Directed scoreboard bench for parity_gen_chk at WIDTH=8 and WIDTH=7.
module tb_parity_gen_chk;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic pbit;
        logic en;
    } gen_exp_t;

    gen_exp_t gq8[$];
    gen_exp_t gq7[$];
    logic     cq8[$];
    logic     cq7[$];

    parity_gen_chk_if #(.WIDTH(8), .MODE_W(3)) b8();
    parity_gen_chk_if #(.WIDTH(7), .MODE_W(3)) b7();

    parity_gen_chk #(.WIDTH(8), .MODE_W(3)) u8 (.CLK(clk), .RST(rst_n), .bus(b8.slave));
    parity_gen_chk #(.WIDTH(7), .MODE_W(3)) u7 (.CLK(clk), .RST(rst_n), .bus(b7.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic busy(input int sel);
        return (sel == 7) ? b7.chk_busy : b8.chk_busy;
    endfunction

    function automatic logic done(input int sel);
        return (sel == 7) ? b7.chk_done : b8.chk_done;
    endfunction

    function automatic logic perr(input int sel);
        return (sel == 7) ? b7.par_err : b8.par_err;
    endfunction

    function automatic logic pvalid(input int sel);
        return (sel == 7) ? b7.par_valid : b8.par_valid;
    endfunction

    task automatic drv_gen(input int sel, input logic [2:0] mode, input logic [8:0] data, input logic dv);
        if (sel == 7) begin
            b7.P_DATA = data[6:0]; b7.par_mode = mode; b7.Data_Valid = dv;
        end else begin
            b8.P_DATA = data[7:0]; b8.par_mode = mode; b8.Data_Valid = dv;
        end
    endtask

    task automatic set_mode(input int sel, input logic [2:0] mode);
        if (sel == 7) b7.par_mode = mode;
        else          b8.par_mode = mode;
    endtask

    task automatic drv_ser(input int sel, input logic st, input logic en, input logic b);
        if (sel == 7) begin
            b7.ser_start = st; b7.ser_en = en; b7.ser_bit = b;
        end else begin
            b8.ser_start = st; b8.ser_en = en; b8.ser_bit = b;
        end
    endtask

    task automatic push_chk(input int sel, input logic e);
        if (sel == 7) cq7.push_back(e);
        else          cq8.push_back(e);
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge and any
    // par_valid / chk_done pulse is matched against the scoreboard queues.
    task automatic cycle();
        gen_exp_t g;
        logic     e;
        @(posedge clk);
        #1;
        if (b8.par_valid) begin
            check("gen8_expected", gq8.size() != 0, 1);
            if (gq8.size() != 0) begin
                g = gq8.pop_front();
                check("gen8_par_bit", b8.par_bit, g.pbit);
                check("gen8_par_en", b8.par_en, g.en);
            end
        end
        if (b7.par_valid) begin
            check("gen7_expected", gq7.size() != 0, 1);
            if (gq7.size() != 0) begin
                g = gq7.pop_front();
                check("gen7_par_bit", b7.par_bit, g.pbit);
                check("gen7_par_en", b7.par_en, g.en);
            end
        end
        if (b8.chk_done) begin
            check("chk8_expected", cq8.size() != 0, 1);
            if (cq8.size() != 0) begin
                e = cq8.pop_front();
                check("chk8_par_err", b8.par_err, e);
            end
        end
        if (b7.chk_done) begin
            check("chk7_expected", cq7.size() != 0, 1);
            if (cq7.size() != 0) begin
                e = cq7.pop_front();
                check("chk7_par_err", b7.par_err, e);
            end
        end
    endtask

    task automatic gen(input int sel, input logic [2:0] mode, input logic [8:0] data,
                       input logic exp_bit, input logic exp_en);
        drv_gen(sel, mode, data, 1'b1);
        if (sel == 7) gq7.push_back('{exp_bit, exp_en});
        else          gq8.push_back('{exp_bit, exp_en});
        cycle();
        check("gen_valid_pulse", pvalid(sel), 1);
        drv_gen(sel, mode, data, 1'b0);
        cycle();
        check("gen_valid_once", pvalid(sel), 0);
    endtask

    // Mode is flipped right after ser_start so any relatching would show up.
    task automatic frame(input int sel, input logic [2:0] mode, input logic [8:0] data,
                         input int nbits, input bit complete, input bit with_par,
                         input logic pbit, input logic exp_err, input bit collide);
        set_mode(sel, mode);
        drv_ser(sel, 1'b1, collide, collide);
        cycle();
        check("chk_busy_start", busy(sel), 1);
        check("chk_err_cleared", perr(sel), 0);
        set_mode(sel, (mode == 3'b000) ? 3'b001 : 3'b000);
        for (int i = 0; i < nbits; i++) begin
            drv_ser(sel, 1'b0, 1'b1, data[i]);
            if (complete && !with_par && i == nbits - 1) push_chk(sel, exp_err);
            cycle();
        end
        if (with_par) begin
            drv_ser(sel, 1'b0, 1'b1, pbit);
            push_chk(sel, exp_err);
            cycle();
        end
        drv_ser(sel, 1'b0, 1'b0, 1'b0);
        if (complete) begin
            check("chk_done_pulse", done(sel), 1);
            check("chk_par_err", perr(sel), exp_err);
            cycle();
            check("chk_done_once", done(sel), 0);
            check("chk_back_idle", busy(sel), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drv_gen(8, 3'b000, 9'h000, 1'b0);
        drv_gen(7, 3'b000, 9'h000, 1'b0);
        drv_ser(8, 1'b0, 1'b0, 1'b0);
        drv_ser(7, 1'b0, 1'b0, 1'b0);
        #12;
        check("rst_par_bit", b8.par_bit, 0);
        check("rst_par_en", b8.par_en, 0);
        check("rst_par_valid", b8.par_valid, 0);
        check("rst_chk_busy", b8.chk_busy, 0);
        check("rst_chk_done", b8.chk_done, 0);
        check("rst_par_err", b8.par_err, 0);
        rst_n = 1'b1;
        cycle();

        gen(8, 3'b001, 9'h0A5, 1'b0, 1'b1);
        gen(8, 3'b001, 9'h007, 1'b1, 1'b1);
        gen(8, 3'b010, 9'h0A5, 1'b1, 1'b1);
        gen(8, 3'b011, 9'h0A5, 1'b1, 1'b1);
        gen(8, 3'b100, 9'h0A5, 1'b0, 1'b1);
        gen(8, 3'b000, 9'h0A5, 1'b0, 1'b0);
        gen(8, 3'b111, 9'h0A5, 1'b0, 1'b0);

        drv_gen(8, 3'b001, 9'h007, 1'b1);
        gq8.push_back('{1'b1, 1'b1});
        cycle();
        check("b2b_valid_1", b8.par_valid, 1);
        drv_gen(8, 3'b010, 9'h007, 1'b1);
        gq8.push_back('{1'b0, 1'b1});
        cycle();
        check("b2b_valid_2", b8.par_valid, 1);
        drv_gen(8, 3'b011, 9'h000, 1'b0);
        cycle();
        check("b2b_drained", gq8.size(), 0);

        gen(8, 3'b011, 9'h000, 1'b1, 1'b1);
        drv_gen(8, 3'b000, 9'h0FF, 1'b0);
        repeat (3) cycle();
        check("hold_par_bit", b8.par_bit, 1);
        check("hold_par_en", b8.par_en, 1);

        frame(8, 3'b001, 9'h007, 8, 1, 1, 1'b1, 1'b0, 0);
        frame(8, 3'b001, 9'h007, 8, 1, 1, 1'b0, 1'b1, 0);
        repeat (3) cycle();
        check("err_holds", b8.par_err, 1);
        drv_ser(8, 1'b0, 1'b1, 1'b1);
        cycle();
        drv_ser(8, 1'b0, 1'b0, 1'b0);
        check("idle_ser_en_ignored", b8.chk_busy, 0);
        check("err_holds_idle", b8.par_err, 1);

        frame(8, 3'b000, 9'h0A5, 8, 1, 0, 1'b0, 1'b0, 0);
        drv_ser(8, 1'b0, 1'b1, 1'b1);
        cycle();
        drv_ser(8, 1'b0, 1'b0, 1'b0);
        check("none_no_par_sample", b8.chk_busy, 0);

        frame(8, 3'b001, 9'h007, 4, 0, 0, 1'b0, 1'b0, 0);
        frame(8, 3'b010, 9'h0FF, 8, 1, 1, 1'b1, 1'b0, 0);

        frame(8, 3'b001, 9'h007, 8, 1, 1, 1'b1, 1'b0, 1);

        gen(8, 3'b011, 9'h000, 1'b1, 1'b1);
        frame(8, 3'b001, 9'h007, 3, 0, 0, 1'b0, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_par_bit", b8.par_bit, 0);
        check("async_par_en", b8.par_en, 0);
        check("async_par_valid", b8.par_valid, 0);
        check("async_chk_busy", b8.chk_busy, 0);
        check("async_chk_done", b8.chk_done, 0);
        check("async_par_err", b8.par_err, 0);
        rst_n = 1'b1;
        cycle();

        gen(7, 3'b001, 9'h055, 1'b0, 1'b1);
        gen(7, 3'b010, 9'h055, 1'b1, 1'b1);
        frame(7, 3'b001, 9'h055, 7, 1, 1, 1'b0, 1'b0, 0);
        frame(7, 3'b001, 9'h055, 7, 1, 1, 1'b1, 1'b1, 0);

        repeat (2) cycle();
        check("drain_gen8", gq8.size(), 0);
        check("drain_gen7", gq7.size(), 0);
        check("drain_chk8", cq8.size(), 0);
        check("drain_chk7", cq7.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
